// File: rtl/pipe_stage_chain_pkg.sv
// pipe_stage_chain_pkg: shared widths and default depth for the stage chain.
package pipe_stage_chain_pkg;
  localparam int ADDRESS_LEN = 32;
  localparam int DEFAULT_STAGES = 5;
endpackage

// File: rtl/pipe_stage_chain_reg.sv
// pipe_stage_reg: one pipeline stage register with load, bubble and kill controls.
module pipe_stage_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             bubble,
  input  logic             kill,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else if (kill || bubble) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else if (load) begin
      q_valid <= d_valid;
      q_data  <= d_data;
    end
endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: stallable, flushable linear pipeline with a retire counter.
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int STAGES = DEFAULT_STAGES,
  parameter int WIDTH  = ADDRESS_LEN,
  parameter int FW     = $clog2(STAGES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_ready,
  input  logic [STAGES-1:0]       stall_req,
  input  logic                    flush,
  input  logic [FW-1:0]           flush_upto,
  output logic [STAGES-1:0]       stage_valid,
  output logic [STAGES*WIDTH-1:0] stage_data,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [31:0]             retire_count
);
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] kill;
  logic [FW-1:0]     last_kill;
  assign last_kill = (flush_upto > FW'(STAGES - 1)) ? FW'(STAGES - 1) : flush_upto;
  assign in_ready  = !hold[0] && !flush;
  assign out_valid = stage_valid[STAGES-1];
  assign out_data  = stage_data[(STAGES-1)*WIDTH +: WIDTH];
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             d_valid;
    logic             load;
    logic             bubble;
    logic [WIDTH-1:0] d_data;
    assign hold[k] = |stall_req[STAGES-1:k];
    assign kill[k] = flush && (FW'(k) <= last_kill);
    if (k == 0) begin : g_head
      assign d_valid = in_valid;
      assign d_data  = in_valid ? in_data : '0;
      assign load    = !hold[0];
      assign bubble  = 1'b0;
    end else begin : g_body
      // a killed predecessor hands over nothing, so the stage behind it takes a bubble
      assign d_valid = stage_valid[k-1];
      assign d_data  = stage_data[(k-1)*WIDTH +: WIDTH];
      assign load    = !hold[k] && !hold[k-1] && !kill[k-1];
      assign bubble  = !hold[k] && (hold[k-1] || kill[k-1]);
    end
    pipe_stage_reg #(.WIDTH(WIDTH)) u_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .bubble  (bubble),
      .kill    (kill[k]),
      .d_valid (d_valid),
      .d_data  (d_data),
      .q_valid (stage_valid[k]),
      .q_data  (stage_data[k*WIDTH +: WIDTH])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) retire_count <= '0;
    else if (out_valid && !stall_req[STAGES-1]) retire_count <= retire_count + 32'd1;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed stimulus with a retire-order scoreboard for pipe_stage_chain.
module tb_pipe_stage_chain;
  localparam int S  = 5;
  localparam int W  = 32;
  localparam int FW = 3;
  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic [S-1:0]   stall_req;
  logic           flush;
  logic [FW-1:0]  flush_upto;
  logic [S-1:0]   stage_valid;
  logic [S*W-1:0] stage_data;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [31:0]    retire_count;
  logic [31:0]    sb[$];
  logic [31:0]    exp_cnt;
  int             vectors = 0;
  int             miscompares = 0;

  pipe_stage_chain #(.STAGES(S), .WIDTH(W), .FW(FW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .stall_req    (stall_req),
    .flush        (flush),
    .flush_upto   (flush_upto),
    .stage_valid  (stage_valid),
    .stage_data   (stage_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  function automatic logic [31:0] word(input int k);
    return stage_data[k*W +: W];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    sb.push_back(d);
    cyc();
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    in_data  = '0;
    repeat (n) cyc();
  endtask

  // retire monitor: every entry leaving the last stage must match the oldest expected entry
  always @(negedge clk)
    if (rst_n) begin
      chk("retire_count", retire_count, exp_cnt);
      if (out_valid && !stall_req[S-1]) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL retire_unexpected: got out_data %h, required no retire", out_data);
        end else chk("retire_data", out_data, sb.pop_front());
        exp_cnt = exp_cnt + 32'd1;
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; stall_req = '0; flush = 1'b0; flush_upto = '0;
    exp_cnt = '0;
    #1;
    chk("reset_stage_valid", 32'(stage_valid), 32'd0);
    chk("reset_stage_data_or", 32'(|stage_data), 32'd0);
    chk("reset_retire_count", retire_count, 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    // stream: 0x10 accepted at edge 1, seen at the output after edge 5
    push(32'h10); push(32'h14); push(32'h18);
    drain(2);
    chk("stream_out_valid", 32'(out_valid), 32'd1);
    chk("stream_out_data", out_data, 32'h10);
    drain(3);
    chk("stream_retired", retire_count, 32'd3);
    drain(3);
    // stall at stage 2 freezes stages 0..2 and bubbles stage 3
    push(32'h31); push(32'h32); push(32'h33);
    in_valid = 1'b1; in_data = 32'h34; stall_req = 5'b00100;
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    cyc();
    chk("stall1_valid", 32'(stage_valid), 32'b00111);
    chk("stall1_stage2", word(2), 32'h31);
    cyc();
    chk("stall2_valid", 32'(stage_valid), 32'b00111);
    chk("stall2_stage0", word(0), 32'h33);
    stall_req = '0;
    push(32'h34);
    chk("unstall_valid", 32'(stage_valid), 32'b01111);
    chk("unstall_stage3", word(3), 32'h31);
    drain(8);
    // flush up to stage 1 with 0x20,0x1C,0x18 in stages 0..2
    push(32'h18); push(32'h1C); push(32'h20);
    in_valid = 1'b0; flush = 1'b1; flush_upto = 3'd1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    cyc();
    void'(sb.pop_back()); void'(sb.pop_back());
    flush = 1'b0;
    chk("flush_valid", 32'(stage_valid), 32'b01000);
    chk("flush_stage3", word(3), 32'h18);
    chk("flush_stage1", word(1), 32'h0);
    drain(8);
    // flush up to stage 2 while stage 3 is stalled; the offered input is dropped
    push(32'h41); push(32'h42); push(32'h43); push(32'h44);
    in_valid = 1'b1; in_data = 32'h45; stall_req = 5'b01000; flush = 1'b1; flush_upto = 3'd2;
    cyc();
    void'(sb.pop_back()); void'(sb.pop_back()); void'(sb.pop_back());
    stall_req = '0; flush = 1'b0;
    chk("flstall_valid", 32'(stage_valid), 32'b01000);
    chk("flstall_stage3", word(3), 32'h41);
    drain(8);
    chk("count_before_laststall", retire_count, 32'd9);
    // stall of the last stage blocks retirement
    push(32'h61);
    drain(4);
    stall_req = 5'b10000;
    #1;
    chk("laststall_in_ready", 32'(in_ready), 32'd0);
    cyc(); cyc();
    chk("laststall_valid", 32'(stage_valid), 32'b10000);
    chk("laststall_count", retire_count, 32'd9);
    stall_req = '0;
    drain(3);
    chk("laststall_released", retire_count, 32'd10);
    // flush_upto beyond the last stage clamps to a full flush
    push(32'h51); push(32'h52);
    flush = 1'b1; flush_upto = 3'd7;
    cyc();
    void'(sb.pop_back()); void'(sb.pop_back());
    flush = 1'b0; flush_upto = '0;
    chk("clamp_valid", 32'(stage_valid), 32'd0);
    drain(6);
    // counter wrap
    force dut.retire_count = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count;
    exp_cnt = 32'hFFFF_FFFF;
    push(32'h71);
    drain(8);
    chk("wrap_count", retire_count, 32'h0);
    // asynchronous reset mid-stream with four valid stages
    push(32'h81); push(32'h82); push(32'h83); push(32'h84);
    in_valid = 1'b0;
    chk("pre_reset_valid", 32'(stage_valid), 32'b01111);
    @(negedge clk); #2;
    rst_n = 1'b0;
    sb.delete();
    exp_cnt = '0;
    #1;
    chk("midreset_valid", 32'(stage_valid), 32'd0);
    chk("midreset_data_or", 32'(|stage_data), 32'd0);
    chk("midreset_out_data", out_data, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    push(32'h91);
    chk("restart_valid", 32'(stage_valid), 32'b00001);
    chk("restart_stage0", word(0), 32'h91);
    push(32'h92);
    drain(8);
    chk("restart_count", retire_count, 32'd2);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
